// File: rtl/mmu_pkg.sv
// Shared Sv48 MMU definitions: permission struct, PTE field positions,
// level/VPN-slice geometry, walker state and PTE classification enums.
package mmu_pkg;

    localparam int VPN_BITS       = 36;
    localparam int PPN_BITS       = 44;
    localparam int EXTENDED_VPN   = 64;
    localparam int EXTENDED_PPN   = 64;
    localparam int OFFSET_BITS    = 12;
    localparam int LEVELS         = 4;
    localparam int VPN_SLICE_BITS = 9;

    localparam int PTE_V       = 0;
    localparam int PTE_R       = 1;
    localparam int PTE_W       = 2;
    localparam int PTE_X       = 3;
    localparam int PTE_PPN_LSB = 10;
    localparam int PTE_PPN_MSB = 53;

    typedef struct packed {
        logic d;
        logic a;
        logic g;
        logic u;
        logic x;
        logic w;
        logic r;
        logic v;
    } tlb_perm_bits;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_REQ  = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_RESP     = 2'd3
    } walk_state_t;

    typedef enum logic [1:0] {
        PTE_INVALID    = 2'd0,
        PTE_POINTER    = 2'd1,
        PTE_LEAF       = 2'd2,
        PTE_MISALIGNED = 2'd3
    } pte_kind_t;

    function automatic logic [VPN_SLICE_BITS-1:0] vpn_slice(
        input logic [VPN_BITS-1:0] vpn,
        input logic [1:0]          level
    );
        case (level)
            2'd0:    return vpn[8:0];
            2'd1:    return vpn[17:9];
            2'd2:    return vpn[26:18];
            2'd3:    return vpn[35:27];
            default: return 9'd0;
        endcase
    endfunction

    // PPN bits that a superpage leaf at this level replaces with VA bits
    function automatic logic [PPN_BITS-1:0] superpage_mask(input logic [1:0] level);
        case (level)
            2'd0:    return 44'h000_0000_0000;
            2'd1:    return 44'h000_0000_01FF;
            2'd2:    return 44'h000_0003_FFFF;
            2'd3:    return 44'h000_07FF_FFFF;
            default: return 44'h000_0000_0000;
        endcase
    endfunction

    function automatic logic [EXTENDED_PPN-1:0] pte_addr(
        input logic [PPN_BITS-1:0]       table_ppn,
        input logic [VPN_SLICE_BITS-1:0] index
    );
        return {8'd0, table_ppn, index, 3'd0};
    endfunction

endpackage

// File: rtl/page_table_walker_if.sv
// TLB-to-walker translation channel plus the walker's PTE memory read port.
interface page_table_walker_if;
    import mmu_pkg::*;

    logic [PPN_BITS-1:0]     satp_ppn;
    logic                    req_valid;
    logic [EXTENDED_VPN-1:0] req_addr;
    logic                    resp_valid;
    logic [EXTENDED_PPN-1:0] resp_addr;
    tlb_perm_bits            resp_perm_bits;
    logic                    mem_req_valid;
    logic [63:0]             mem_req_addr;
    logic                    mem_req_ready;
    logic                    mem_resp_valid;
    logic [63:0]             mem_resp_data;

    modport master (
        output satp_ppn, req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  resp_valid, resp_addr, resp_perm_bits, mem_req_valid, mem_req_addr
    );

    modport slave (
        input  satp_ppn, req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
        output resp_valid, resp_addr, resp_perm_bits, mem_req_valid, mem_req_addr
    );

endinterface

// File: rtl/pte_decode.sv
// Combinational PTE classification and leaf physical-address composition
// for a PTE fetched at a given walk level.
module pte_decode
    import mmu_pkg::*;
(
    input  logic [63:0]             pte,
    input  logic [1:0]              level,
    input  logic [VPN_BITS-1:0]     vpn,
    output pte_kind_t               kind,
    output logic [PPN_BITS-1:0]     ppn,
    output logic [EXTENDED_PPN-1:0] leaf_addr,
    output tlb_perm_bits            perm
);

    logic [PPN_BITS-1:0] mask_s;
    logic [PPN_BITS-1:0] leaf_ppn_s;
    logic                unused_bits_s;

    assign ppn           = pte[PTE_PPN_MSB:PTE_PPN_LSB];
    assign perm          = pte[7:0];
    assign mask_s        = superpage_mask(level);
    assign leaf_ppn_s    = (ppn & ~mask_s) | ({8'd0, vpn} & mask_s);
    assign leaf_addr     = {{(EXTENDED_PPN-PPN_BITS-OFFSET_BITS){1'b0}}, leaf_ppn_s, {OFFSET_BITS{1'b0}}};
    assign unused_bits_s = ^{pte[63:54], pte[9:8]};

    // Classify; a pointer found at the last level has nowhere to go and is a fault
    always_comb begin
        kind = PTE_INVALID;
        if (!pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W])) begin
            kind = PTE_INVALID;
        end else if (!pte[PTE_R] && !pte[PTE_X]) begin
            if (level == 2'd0) begin
                kind = PTE_INVALID;
            end else begin
                kind = PTE_POINTER;
            end
        end else if ((ppn & mask_s) != 44'd0) begin
            kind = PTE_MISALIGNED;
        end else begin
            kind = PTE_LEAF;
        end
    end

endmodule

// File: rtl/page_table_walker.sv
// Sv48 page-table walker: translates one VA per request by reading up to
// four PTEs, returning the physical page address and leaf permission bits.
module page_table_walker
    import mmu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    page_table_walker_if.slave  bus
);

    walk_state_t             state_r, state_s;
    logic [1:0]              level_r, level_s;
    logic [VPN_BITS-1:0]     vpn_r, vpn_s;
    logic [63:0]             mem_addr_r, mem_addr_s;
    logic [EXTENDED_PPN-1:0] resp_addr_r, resp_addr_s;
    tlb_perm_bits            resp_perm_r, resp_perm_s;

    pte_kind_t               kind_s;
    logic [PPN_BITS-1:0]     next_ppn_s;
    logic [EXTENDED_PPN-1:0] leaf_addr_s;
    tlb_perm_bits            leaf_perm_s;
    logic                    non_canonical_s;
    logic                    unused_req_s;

    assign non_canonical_s = (bus.req_addr[63:47] != 17'h0_0000) &&
                             (bus.req_addr[63:47] != 17'h1_FFFF);
    assign unused_req_s    = ^bus.req_addr[OFFSET_BITS-1:0];

    pte_decode u_pte_decode (
        .pte       (bus.mem_resp_data),
        .level     (level_r),
        .vpn       (vpn_r),
        .kind      (kind_s),
        .ppn       (next_ppn_s),
        .leaf_addr (leaf_addr_s),
        .perm      (leaf_perm_s)
    );

    assign bus.mem_req_valid  = (state_r == ST_MEM_REQ);
    assign bus.resp_valid     = (state_r == ST_RESP);
    assign bus.mem_req_addr   = mem_addr_r;
    assign bus.resp_addr      = resp_addr_r;
    assign bus.resp_perm_bits = resp_perm_r;

    // Walker state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            level_r     <= 2'd0;
            vpn_r       <= '0;
            mem_addr_r  <= 64'd0;
            resp_addr_r <= 64'd0;
            resp_perm_r <= 8'd0;
        end else begin
            state_r     <= state_s;
            level_r     <= level_s;
            vpn_r       <= vpn_s;
            mem_addr_r  <= mem_addr_s;
            resp_addr_r <= resp_addr_s;
            resp_perm_r <= resp_perm_s;
        end
    end

    // Next-state: the PTE is judged in the same cycle its data arrives
    always_comb begin
        state_s     = state_r;
        level_s     = level_r;
        vpn_s       = vpn_r;
        mem_addr_s  = mem_addr_r;
        resp_addr_s = resp_addr_r;
        resp_perm_s = resp_perm_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    vpn_s   = bus.req_addr[47:12];
                    level_s = 2'(LEVELS - 1);
                    if (non_canonical_s) begin
                        resp_addr_s = 64'd0;
                        resp_perm_s = 8'd0;
                        state_s     = ST_RESP;
                    end else begin
                        mem_addr_s = pte_addr(bus.satp_ppn, vpn_slice(bus.req_addr[47:12], 2'd3));
                        state_s    = ST_MEM_REQ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MEM_REQ: begin
                if (bus.mem_req_ready) begin
                    state_s = ST_MEM_WAIT;
                end else begin
                    state_s = ST_MEM_REQ;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_resp_valid) begin
                    case (kind_s)
                        PTE_POINTER: begin
                            level_s    = level_r - 2'd1;
                            mem_addr_s = pte_addr(next_ppn_s, vpn_slice(vpn_r, level_r - 2'd1));
                            state_s    = ST_MEM_REQ;
                        end
                        PTE_LEAF: begin
                            resp_addr_s = leaf_addr_s;
                            resp_perm_s = leaf_perm_s;
                            state_s     = ST_RESP;
                        end
                        default: begin
                            resp_addr_s = 64'd0;
                            resp_perm_s = 8'd0;
                            state_s     = ST_RESP;
                        end
                    endcase
                end else begin
                    state_s = ST_MEM_WAIT;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/page_table_walker.md
# page_table_walker

Sv48 hardware page-table walker: the responder on the TLB-to-MMU translation channel. It accepts a virtual address from a D-TLB or I-TLB miss and reads up to four PTEs through a single 64-bit memory read port. It returns the physical page address and the leaf PTE's permission bits, or a fault indication. One instance serves each TLB; an external arbiter, outside this block, shares the memory port between instances.

## Interface
- VPN_BITS, 36, Sv48 virtual page number width
- PPN_BITS, 44, Sv48 physical page number width
- EXTENDED_VPN, 64, width of the request address
- EXTENDED_PPN, 64, width of the response and memory addresses
- OFFSET_BITS, 12, page offset width
- LEVELS, 4, page-table depth; fixed at 4 for Sv48

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- satp_ppn  in  PPN_BITS  root table PPN; sampled at walk start
- req_valid  in  1  translation request; held high by the TLB until resp_valid
- req_addr  in  EXTENDED_VPN  virtual address to translate
- resp_valid  out  1  one-cycle pulse; response fields valid
- resp_addr  out  EXTENDED_PPN  physical address, low OFFSET_BITS zero
- resp_perm_bits  out  tlb_perm_bits  leaf PTE bits [7:0]; v=0 signals a fault
- mem_req_valid  out  1  PTE read request
- mem_req_addr  out  64  8-byte-aligned PTE address
- mem_req_ready  in  1  memory accepts the request when valid&&ready
- mem_resp_valid  in  1  PTE data valid, one cycle
- mem_resp_data  in  64  PTE

## Operation
- tlb_perm_bits is a packed struct, MSB to LSB: d,a,g,u,x,w,r,v. It equals PTE[7:0].
- PTE PPN field is PTE[53:10].
- States:
  - IDLE: on req_valid, latch va=req_addr and root=satp_ppn, set level=3.
    - If va[63:48] is not all equal to va[47] (non-canonical), go to RESP with a fault and no memory access.
    - Otherwise go to MEM_REQ.
  - MEM_REQ: mem_req_valid=1, mem_req_addr = (table_ppn<<12) + (vpn[level]<<3), with vpn[i]=va[12+9i+8:12+9i]. On ready, go to MEM_WAIT.
  - MEM_WAIT: wait for mem_resp_valid, then evaluate the PTE in the same cycle:
    - v=0, or (r=0 && w=1): fault, go to RESP.
    - r=0 && x=0 (pointer): if level=0, fault. Otherwise set table_ppn=PTE.PPN, level-1, go to MEM_REQ.
    - Leaf at level L>0: PTE.PPN low 9L bits must be zero, otherwise fault (misaligned superpage). resp_addr = {PTE.PPN upper bits, va[12+9L-1:12], 12'b0}.
    - Leaf at level 0: resp_addr = PTE.PPN<<12.
    - Leaf: resp_perm_bits = PTE[7:0], go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
- Fault response: resp_addr=0, resp_perm_bits=0.
- The walker does not set A or D bits and performs no permission checks. Those belong to the consumer.
- mem_resp_valid outside MEM_WAIT is ignored.
- req_valid is not re-sampled until IDLE.

## Timing
- Reset values: resp_valid=0, resp_addr=0, resp_perm_bits=0, mem_req_valid=0, mem_req_addr=0, state=IDLE, level=0.
- mem_req_valid and resp_valid decode from registered state. resp_addr and resp_perm_bits are registered and hold until the next RESP.
- The request is accepted in cycle 0 (IDLE). With mem_req_ready=1 and memory latency of one cycle, each level costs 2 cycles.
  - Full 4-level walk: resp_valid in cycle 9.
  - Leaf at level 3: resp_valid in cycle 3.
  - Non-canonical fault: resp_valid in cycle 1.
- mem_req_addr is stable while mem_req_valid is high and ready is low.
- The TLB drops req_valid on the edge ending the RESP cycle, so IDLE never re-accepts a stale request.
- Reset asserted mid-walk forces IDLE immediately and drops mem_req_valid asynchronously. Any late memory response is ignored.

## Structure
- Shared package mmu_pkg holds:
  - tlb_perm_bits typedef
  - PTE bit-position constants
  - Sv48 level/VPN-slice constants
  - walker state enum
- The TLBs import mmu_pkg.
- One natural sub-module, pte_decode: combinational PTE classification (invalid / pointer / leaf / misaligned) and superpage address composition. The FSM stays in page_table_walker.

## Test plan
- Base walk: satp_ppn=0x100, va=0x403000, all table memory single-cycle.
  - PTE at 0x100000 = 0x40401; at 0x101000 = 0x40801; at 0x102010 = 0x40C01; at 0x103018 = 0x200000CF.
  - Required: resp_addr=0x80000000, resp_perm_bits=0xCF, resp_valid in cycle 9, exactly 4 memory reads.
- 2 MiB superpage: same setup, but the PTE at 0x102010 is (0x80200<<10)|0xCF.
  - Required: resp_addr=0x80203000, 3 reads.
  - Same with PPN 0x80201: fault, perms=0, resp_addr=0.
- Invalid PTE: PTE at 0x101000 = 0x0.
  - Required: fault after 2 reads.
  - Same with PTE 0x5 (w without r): fault.
- Non-canonical va=0x0001000000000000.
  - Required: no mem_req_valid, fault with resp_valid in cycle 1.
- Backpressure: mem_req_ready low 3 cycles per request, response latency 4 cycles.
  - Required: mem_req_addr stable while stalled, result identical to the base walk.
- Reset low during MEM_WAIT of level 1, then a stale mem_resp_valid after release.
  - Required: all outputs return to zero, state IDLE, stale response ignored. Next request walks correctly.
